// File: rtl/hs_buf_pkg.sv
// Shared types and data-word layout for the hold-slave request buffer.
// The word-layout constants mirror the shared global header values.
package hs_buf_pkg;

  localparam int IR_DATA_WIDTH = 32;
  localparam int NUM_PORT      = 5;
  localparam int SRC_LIST_POS  = 0;
  localparam int HS_POS        = IR_DATA_WIDTH - 1;

  typedef struct packed {
    logic push;
    logic pop;
    logic head_wr;
  } fifo_ctl_t;

  function automatic logic [NUM_PORT-1:0] src_list(input logic [IR_DATA_WIDTH-1:0] w);
    return w[SRC_LIST_POS +: NUM_PORT];
  endfunction

endpackage

// File: rtl/hs_fifo.sv
// Circular HS entry store with read/write pointers, count and a head-overwrite
// port used to write back the merged master.
module hs_fifo
  import hs_buf_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = IR_DATA_WIDTH,
  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  fifo_ctl_t     ctl,
  input  logic [W-1:0]  push_data,
  input  logic [W-1:0]  head_wr_data,
  output logic [W-1:0]  head_data,
  output logic [CW-1:0] count,
  output logic          full
);

  logic [DEPTH-1:0][W-1:0] mem;
  logic [PW-1:0]           rd_ptr, wr_ptr;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign head_data = mem[rd_ptr];
  assign full      = (count == CW'(DEPTH));

  // The caller never pops and overwrites the head in the same cycle, and never
  // pushes when full, so the two writes below never target the same slot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem <= '0;
    end else begin
      if (ctl.push)    mem[wr_ptr] <= push_data;
      if (ctl.head_wr) mem[rd_ptr] <= head_wr_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (ctl.push) wr_ptr <= ptr_inc(wr_ptr);
      if (ctl.pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({ctl.push, ctl.pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/hs_buf.sv
// HS request buffer: holds the head entry as merge master for a bounded window,
// qualifies kills from merge_buf, then drains the head under valid/ready.
module hs_buf
  import hs_buf_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int HOLD_CYCLES = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enq_valid,
  input  logic [IR_DATA_WIDTH-1:0] enq_data,
  output logic                     enq_ready,
  output logic [IR_DATA_WIDTH-1:0] hs_master_buf,
  output logic                     master_valid,
  input  logic [IR_DATA_WIDTH-1:0] hs_master_buf_in,
  input  logic [NUM_PORT-1:0]      kill_in,
  input  logic [NUM_PORT-1:0]      port_valid,
  output logic [NUM_PORT-1:0]      kill_out,
  output logic                     deq_valid,
  output logic [IR_DATA_WIDTH-1:0] deq_data,
  input  logic                     deq_ready
);

  localparam int TW = $clog2(HOLD_CYCLES + 1);
  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_HOLD  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  if (DEPTH < 2)       $error("hs_buf: DEPTH must be >= 2");
  if (HOLD_CYCLES < 1) $error("hs_buf: HOLD_CYCLES must be >= 1");

  logic [1:0]    state;
  logic [TW-1:0] timer;
  logic [CW-1:0] count;
  logic          full;
  logic          enq_fire, deq_fire;
  fifo_ctl_t     ctl;

  assign enq_ready    = !full;
  assign enq_fire     = enq_valid & enq_ready;
  assign deq_valid    = (state == ST_DRAIN);
  assign deq_fire     = deq_valid & deq_ready;
  assign master_valid = (state != ST_EMPTY);
  assign deq_data     = hs_master_buf;

  // Kills only count while the head is an open merge target.
  assign kill_out = (state == ST_HOLD) ? (kill_in & port_valid) : '0;

  assign ctl.push    = enq_fire;
  assign ctl.pop     = deq_fire;
  assign ctl.head_wr = |kill_out;

  hs_fifo #(
    .DEPTH (DEPTH),
    .W     (IR_DATA_WIDTH)
  ) u_fifo (
    .clk          (clk),
    .reset        (reset),
    .ctl          (ctl),
    .push_data    (enq_data),
    .head_wr_data (hs_master_buf_in),
    .head_data    (hs_master_buf),
    .count        (count),
    .full         (full)
  );

  // A full buffer cuts the window short so the producer is not stalled for the
  // rest of the timer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_EMPTY;
      timer <= '0;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (enq_fire) begin
            state <= ST_HOLD;
            timer <= TW'(HOLD_CYCLES - 1);
          end
        end
        ST_HOLD: begin
          if (timer == '0 || full) state <= ST_DRAIN;
          else                     timer <= timer - TW'(1);
        end
        ST_DRAIN: begin
          if (deq_fire) begin
            if (count > CW'(1) || enq_fire) begin
              state <= ST_HOLD;
              timer <= TW'(HOLD_CYCLES - 1);
            end else begin
              state <= ST_EMPTY;
            end
          end
        end
        default: state <= ST_EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_hs_buf.sv
// Directed bench for hs_buf: vector table for hold/merge/drain, plus hand
// sequences for full, backpressure and asynchronous reset.
module tb_hs_buf;
  import hs_buf_pkg::*;

  localparam int DEPTH = 4;
  localparam int HOLD  = 8;
  localparam int W     = IR_DATA_WIDTH;
  localparam int NP    = NUM_PORT;
  localparam int NV    = 22;

  logic          clk = 1'b0;
  logic          reset;
  logic          enq_valid;
  logic [W-1:0]  enq_data;
  logic          enq_ready;
  logic [W-1:0]  hs_master_buf;
  logic          master_valid;
  logic [W-1:0]  hs_master_buf_in;
  logic [NP-1:0] kill_in, port_valid, kill_out;
  logic          deq_valid;
  logic [W-1:0]  deq_data;
  logic          deq_ready;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  hs_buf #(.DEPTH(DEPTH), .HOLD_CYCLES(HOLD)) dut (
    .clk              (clk),
    .reset            (reset),
    .enq_valid        (enq_valid),
    .enq_data         (enq_data),
    .enq_ready        (enq_ready),
    .hs_master_buf    (hs_master_buf),
    .master_valid     (master_valid),
    .hs_master_buf_in (hs_master_buf_in),
    .kill_in          (kill_in),
    .port_valid       (port_valid),
    .kill_out         (kill_out),
    .deq_valid        (deq_valid),
    .deq_data         (deq_data),
    .deq_ready        (deq_ready)
  );

  typedef struct {
    logic          ev;
    logic [W-1:0]  ed;
    logic [NP-1:0] ki, pv;
    logic [W-1:0]  mi;
    logic          dr;
    logic          er, mv, dv;
    logic [NP-1:0] ko;
    logic [W-1:0]  dd;
  } vec_t;

  vec_t tbl[NV];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  localparam logic [W-1:0] W1 = 32'h1234_5600;
  localparam logic [W-1:0] W2 = 32'hCAFE_0001;
  localparam logic [W-1:0] M  = 32'hD00D_0005;
  localparam logic [W-1:0] X  = 32'h7777_0010;

  logic [W-1:0] f [4];

  initial begin
    vec_t d;
    f[0] = 32'hF000_0001; f[1] = 32'hF111_0002; f[2] = 32'hF222_0004; f[3] = 32'hF333_0008;

    d = '{ev:1'b0, ed:'0, ki:'0, pv:'0, mi:'0, dr:1'b1,
          er:1'b1, mv:1'b0, dv:1'b0, ko:'0, dd:'0};
    for (int i = 0; i < NV; i++) tbl[i] = d;
    tbl[0].ev = 1'b1; tbl[0].ed = W1;
    for (int i = 1; i <= 9; i++) begin tbl[i].mv = 1'b1; tbl[i].dd = W1; end
    tbl[9].dv = 1'b1;
    tbl[5].ki = 5'b01011; tbl[5].pv = 5'b01110; tbl[5].mi = W1; tbl[5].ko = 5'b01010;
    tbl[10].ki = '1; tbl[10].pv = '1; tbl[10].mi = '1;
    tbl[11].ev = 1'b1; tbl[11].ed = W2;
    for (int i = 12; i <= 20; i++) begin tbl[i].mv = 1'b1; tbl[i].dd = (i <= 14) ? W2 : M; end
    tbl[20].dv = 1'b1;
    tbl[14].ki = 5'b00100; tbl[14].pv = 5'b00100; tbl[14].mi = M; tbl[14].ko = 5'b00100;
    tbl[16].ki = 5'b11111; tbl[16].pv = 5'b00000; tbl[16].mi = '1;

    reset = 1'b1; enq_valid = 1'b0; enq_data = '0; hs_master_buf_in = '0;
    kill_in = '0; port_valid = '0; deq_ready = 1'b0;
    #12;
    chk("rst_enq_ready", W'(enq_ready), W'(1'b1));
    chk("rst_master_valid", W'(master_valid), '0);
    chk("rst_deq_valid", W'(deq_valid), '0);
    chk("rst_deq_data", deq_data, '0);
    @(negedge clk) reset = 1'b0;
    step();

    for (int i = 0; i < NV; i++) begin
      enq_valid = tbl[i].ev; enq_data = tbl[i].ed; kill_in = tbl[i].ki;
      port_valid = tbl[i].pv; hs_master_buf_in = tbl[i].mi; deq_ready = tbl[i].dr;
      @(negedge clk);
      chk($sformatf("v%0d_enq_ready", i), W'(enq_ready), W'(tbl[i].er));
      chk($sformatf("v%0d_master_valid", i), W'(master_valid), W'(tbl[i].mv));
      chk($sformatf("v%0d_deq_valid", i), W'(deq_valid), W'(tbl[i].dv));
      chk($sformatf("v%0d_kill_out", i), W'(kill_out), W'(tbl[i].ko));
      if (tbl[i].mv) chk($sformatf("v%0d_deq_data", i), deq_data, tbl[i].dd);
      if (i == 15) chk("merge_src", W'(src_list(hs_master_buf)), W'(5'b00101));
      step();
    end
    enq_valid = 1'b0; kill_in = '0; port_valid = '0; hs_master_buf_in = '0;

    // Fill from empty with downstream stalled.
    deq_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      enq_valid = 1'b1; enq_data = f[k];
      @(negedge clk);
      chk($sformatf("fill%0d_enq_ready", k), W'(enq_ready), W'(1'b1));
      step();
    end
    enq_data = 32'hBAD0_0BAD;
    @(negedge clk);
    chk("full_enq_ready", W'(enq_ready), '0);
    chk("full_still_hold", W'(deq_valid), '0);
    step();

    // Early drain, then held under backpressure with all ports killing.
    kill_in = '1; port_valid = '1; hs_master_buf_in = '1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("bp%0d_deq_valid", k), W'(deq_valid), W'(1'b1));
      chk($sformatf("bp%0d_deq_data", k), deq_data, f[0]);
      chk($sformatf("bp%0d_kill_out", k), W'(kill_out), '0);
      chk($sformatf("bp%0d_enq_ready", k), W'(enq_ready), '0);
      step();
    end
    enq_valid = 1'b0; kill_in = '0; port_valid = '0; hs_master_buf_in = '0; deq_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_valid", W'(deq_valid), W'(1'b1));
    step();

    // Next entry gets a fresh full window; a fifth accepted word would re-fill and cut it short.
    for (int j = 0; j < HOLD; j++) begin
      @(negedge clk);
      chk($sformatf("win%0d_deq_valid", j), W'(deq_valid), '0);
      chk($sformatf("win%0d_deq_data", j), deq_data, f[1]);
      step();
    end
    enq_valid = 1'b1; enq_data = 32'h5555_0003;
    @(negedge clk);
    chk("win_end_deq_valid", W'(deq_valid), W'(1'b1));
    chk("win_end_deq_data", deq_data, f[1]);
    step();
    enq_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_head", deq_data, f[2]);
    chk("pre_rst_master_valid", W'(master_valid), W'(1'b1));

    // Asynchronous reset in the middle of a HOLD cycle with three entries queued.
    kill_in = '1; port_valid = '1;
    #2 reset = 1'b1;
    #1;
    chk("arst_master_valid", W'(master_valid), '0);
    chk("arst_deq_valid", W'(deq_valid), '0);
    chk("arst_kill_out", W'(kill_out), '0);
    chk("arst_enq_ready", W'(enq_ready), W'(1'b1));
    chk("arst_deq_data", deq_data, '0);
    step();
    chk("arst_held_master_valid", W'(master_valid), '0);
    @(negedge clk);
    reset = 1'b0; kill_in = '0; port_valid = '0;
    step();

    enq_valid = 1'b1; enq_data = X;
    @(negedge clk);
    chk("post_rst_idle", W'(master_valid), '0);
    step();
    enq_valid = 1'b0;
    for (int j = 0; j < HOLD; j++) begin
      @(negedge clk);
      chk($sformatf("post%0d_master_valid", j), W'(master_valid), W'(1'b1));
      chk($sformatf("post%0d_deq_valid", j), W'(deq_valid), '0);
      step();
    end
    @(negedge clk);
    chk("post_deq_valid", W'(deq_valid), W'(1'b1));
    chk("post_deq_data", deq_data, X);
    step();
    @(negedge clk);
    chk("post_empty", W'(master_valid), '0);
    chk("post_enq_ready", W'(enq_ready), W'(1'b1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hs_buf.md
# hs_buf

Hold-slave (HS) request buffer that sits directly around `merge_buf`. It queues incoming HS request words and presents the head entry (the "master") to `merge_buf` for a bounded merge window. It accepts the merged head back whenever a flit is killed, then releases the master downstream under a valid/ready handshake.

## Interface

Parameters:
- `DEPTH`, 4: number of HS entries, including the head; must be ≥2.
- `HOLD_CYCLES`, 8: length of the merge window in cycles; must be ≥1.
- Widths come from `global.vh`: `IR_DATA_WIDTH`, `NUM_PORT`.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `enq_valid`  in  1  new HS request word offered.
- `enq_data`  in  `IR_DATA_WIDTH`  HS request word.
- `enq_ready`  out  1  buffer can accept; equals count < DEPTH.
- `hs_master_buf`  out  `IR_DATA_WIDTH`  head entry, driven to `merge_buf`.
- `master_valid`  out  1  head entry is in HOLD or DRAIN.
- `hs_master_buf_in`  in  `IR_DATA_WIDTH`  merged head returned by `merge_buf`.
- `kill_in`  in  `NUM_PORT`  raw per-port match from `merge_buf`.
- `port_valid`  in  `NUM_PORT`  per-port flit-valid for the current cycle.
- `kill_out`  out  `NUM_PORT`  qualified kill sent to the input ports; those flits are dropped.
- `deq_valid`  out  1  head is released downstream.
- `deq_data`  out  `IR_DATA_WIDTH`  equals `hs_master_buf`.
- `deq_ready`  in  1  downstream accepts.

## Operation

- Circular FIFO with DEPTH entries, a read pointer, a write pointer and a count. The head (read pointer) is the master.
- Enqueue fires on `enq_valid & enq_ready`.
- Dequeue fires on `deq_valid & deq_ready`.
- If both fire in the same cycle, count is unchanged.
- Head FSM states: EMPTY, HOLD, DRAIN.
  - EMPTY → HOLD on the cycle the head becomes occupied. The timer loads `HOLD_CYCLES-1`.
  - HOLD: if timer == 0 or count == DEPTH, go to DRAIN on the next cycle. Otherwise decrement the timer. Merges never reload the timer.
  - DRAIN: `deq_valid` = 1. On dequeue fire, go to HOLD if count after the pop is > 0 (timer reloaded), else go to EMPTY.
- Merge rule:
  - `kill_out` = `kill_in & port_valid` when state == HOLD; 0 otherwise. It is combinational.
  - When `|kill_out` in HOLD, the head entry loads `hs_master_buf_in` (full word) at the next edge.
- In DRAIN the head is frozen and `deq_data` must stay stable while `deq_valid & !deq_ready`.
- Non-head entries are never modified.
- `master_valid` = (state != EMPTY).

## Timing

- Reset values:
  - count, pointers, timer = 0; state = EMPTY.
  - `deq_valid`, `master_valid`, `kill_out` = 0.
  - `hs_master_buf`, `deq_data` = 0; all entries = 0.
  - `enq_ready` = 1.
- Reset asserted mid-operation drops every pending entry. Outputs take reset values without waiting for a clock edge.
- Enqueue into an empty buffer at edge t:
  - `master_valid` = 1 from cycle t+1.
  - `deq_valid` first at cycle t+1+HOLD_CYCLES, unless early-drained because the buffer is full.
- Merge writeback latency is 1 cycle; `kill_out` has zero-cycle latency relative to `kill_in`/`port_valid`.
- Full: `enq_ready` = 0 while count == DEPTH, even if a dequeue fires in that same cycle. There is no combinational path from `deq_ready` to `enq_ready`.
- A full buffer in HOLD forces DRAIN on the next cycle.
- Pointers wrap modulo DEPTH. Timer width is `$clog2(HOLD_CYCLES+1)`.

## Structure

- `IR_DATA_WIDTH`, `NUM_PORT`, `SRC_LIST_POS` and `HS_POS` stay in the shared `global.vh`. No new global constants are added.
- FSM state encodings are local `localparam`s.
- One sub-module is natural: `hs_fifo`, the storage plus pointers and count, with a head-overwrite port.
- The FSM, timer and kill qualification live in `hs_buf`.

## Test plan

Defaults for all scenarios: DEPTH=4, HOLD_CYCLES=8.

- Single enqueue of `enq_data`=W at cycle 0, no kills, `deq_ready`=1 → `master_valid` at cycle 1; `deq_valid` at cycle 9 with `deq_data`=W; EMPTY and `master_valid`=0 at cycle 10.
- Merge: head src list 5'b00001; at HOLD cycle 3, `port_valid`=`kill_in`=5'b00100 and `hs_master_buf_in` has src 5'b00101 → `kill_out`=5'b00100 the same cycle; head src is 5'b00101 the next cycle; `deq_data` src is 5'b00101; timer not extended.
- Unqualified kill: `kill_in`=5'b11111 with `port_valid`=0 → `kill_out`=0 and the head is unchanged.
- Full: four back-to-back enqueues from empty → `enq_ready`=0 after the fourth; DRAIN one cycle after count reaches 4, well before timer expiry; a fifth `enq_valid` is not accepted.
- Backpressure: `deq_ready`=0 for 5 cycles in DRAIN with `kill_in`=`port_valid`=5'b11111 → `deq_data` stable and `kill_out`=0. After the dequeue fires, the next entry enters HOLD with a full 8-cycle window.
- Reset asserted mid-HOLD with count=3 → all outputs at reset values immediately, `enq_ready`=1; after deassertion the buffer behaves as empty.
